pipe_skid_stage: RTL

- Parametrised pipeline-stage register that generalises the fixed-field inter-stage latches, such as the M->W latch.
- Carries an arbitrary-width payload with a valid/ready handshake instead of a global STALL.
- A 2-entry skid buffer gives a fully registered I_READY while sustaining 1 transfer/cycle.
- Sits between any two CPU-core stages (IF/ID/EX/MEM/WB); payload is the concatenated stage bundle (PC, INST, REG_D, REG_D_V, ...).

---
 rtl/pipe_skid_stage.sv | 99 +++++++++
 1 files changed

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: generic inter-stage pipeline register with a valid/ready
// handshake. A two-entry skid buffer (main + skid) lets I_READY come straight
// from a flop while still sustaining one transfer per cycle.
module pipe_skid_stage #(
    parameter int DATA_W     = 101,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FLUSH,
    input  logic              I_VALID,
    output logic              I_READY,
    input  logic [DATA_W-1:0] I_DATA,
    output logic              O_VALID,
    input  logic              O_READY,
    output logic [DATA_W-1:0] O_DATA,
    output logic [1:0]        O_COUNT
);

    // Encoding equals the number of held entries so O_COUNT is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_d_q, main_d_d;
    logic [DATA_W-1:0] skid_d_q, skid_d_d;

    logic accept;
    logic take;

    // Handshake qualifiers; both come from registered state (plus RST gating).
    always_comb begin
        accept = I_VALID && (state_q != TWO) && !RST;
        take   = (state_q != EMPTY) && O_READY;
    end

    // State and payload registers; RST/FLUSH handling lives in the next-state logic.
    always_ff @(posedge CLK) begin
        state_q  <= state_d;
        main_d_q <= main_d_d;
        skid_d_q <= skid_d_d;
    end

    // Next-state and payload steering; reset beats flush, flush beats any transfer.
    always_comb begin
        state_d  = state_q;
        main_d_d = main_d_q;
        skid_d_d = skid_d_q;
        if (RST || FLUSH) begin
            state_d = EMPTY;
            if (CLEAR_DATA) begin
                main_d_d = '0;
                skid_d_d = '0;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d_d = I_DATA;
                        state_d  = ONE;
                    end
                end
                ONE: begin
                    if (accept && take) begin
                        main_d_d = I_DATA;
                    end else if (accept) begin
                        // Main is still waiting downstream, so park the new word behind it.
                        skid_d_d = I_DATA;
                        state_d  = TWO;
                    end else if (take) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // I_READY is low here, so only a drain can happen.
                    if (take) begin
                        main_d_d = skid_d_q;
                        state_d  = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Outputs are pure decodes of registered state; RST only gates I_READY.
    always_comb begin
        O_VALID = (state_q != EMPTY);
        O_DATA  = main_d_q;
        O_COUNT = state_q;
        I_READY = (state_q != TWO) && !RST;
    end

endmodule
